eh2_dec_gpr_wb_buf: RTL and testbench

- Writeback staging buffer directly upstream of the GPR register file's fourth write port (waddr3/wtid3/wen3/wd3).
- Collects late-returning results from the divider and from non-blocking loads, holds them in an in-order FIFO, and drains one entry per cycle whenever the pipe leaves that write port idle.
- Provides a scoreboard lookup so decode can stall reads of a register that still has a buffered write pending.

---
 rtl/eh2_dec_gpr_wb_buf_if.sv | 26 ++
 rtl/eh2_dec_gpr_wb_buf.sv | 140 ++++++++++++++
 tb/tb_eh2_dec_gpr_wb_buf.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eh2_dec_gpr_wb_buf_if.sv
// GPR write port 3 as seen by the writeback staging buffer.
// master: the buffer, which drives the write and watches port_free.
// slave:  the pipe / register file side.
interface eh2_dec_gpr_wb_buf_if;
  logic        port_free;
  logic        wen;
  logic        wtid;
  logic [4:0]  waddr;
  logic [31:0] wd;

  modport master (
    input  port_free,
    output wen,
    output wtid,
    output waddr,
    output wd
  );

  modport slave (
    output port_free,
    input  wen,
    input  wtid,
    input  waddr,
    input  wd
  );
endinterface

// File: rtl/eh2_dec_gpr_wb_buf.sv
// Writeback staging buffer for GPR write port 3.
// Late divider and non-blocking-load results are queued in order and drained
// one per cycle when the pipe leaves port 3 idle. Flushed entries keep their
// slot with valid=0 and are skipped at the head. A scoreboard lookup reports
// pending writes so decode can stall dependent reads.
module eh2_dec_gpr_wb_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_wen,
  input  logic        div_tid,
  input  logic [4:0]  div_waddr,
  input  logic [31:0] div_wd,
  input  logic        nbl_wen,
  input  logic        nbl_tid,
  input  logic [4:0]  nbl_waddr,
  input  logic [31:0] nbl_wd,
  input  logic [1:0]  flush,
  input  logic        chk_tid,
  input  logic [4:0]  chk_addr,
  output logic        chk_busy,
  output logic        full,
  output logic        ovf_err,
  eh2_dec_gpr_wb_buf_if.master wb
);

  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FULL_I   = DEPTH - 1;
  localparam int TWO_I    = 2;
  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0] FULL_LVL = FULL_I[AW:0];
  localparam logic [AW:0] TWO_C    = TWO_I[AW:0];

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_tid;
  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;

  logic          not_empty;
  logic          head_valid;
  logic          head_tid;
  logic          deq;
  logic          wen_int;
  logic          div_ok;
  logic          nbl_ok;
  logic          div_acc;
  logic          nbl_acc;
  logic          ovf_now;
  logic [AW:0]   space;
  logic [AW:0]   acc_n;
  logic [AW:0]   deq_n;
  logic [AW-1:0] nbl_slot;

  // Head-of-queue drain decision and the resulting port 3 write.
  always_comb begin
    not_empty  = (count != '0);
    head_valid = ent_valid[rptr];
    head_tid   = ent_tid[rptr];
    deq        = wb.port_free && not_empty;
    // A head being flushed this very cycle must not reach the register file.
    wen_int    = deq && head_valid && !flush[head_tid];
  end

  assign wb.wen   = wen_int;
  assign wb.wtid  = wen_int ? head_tid       : 1'b0;
  assign wb.waddr = wen_int ? ent_addr[rptr] : 5'd0;
  assign wb.wd    = wen_int ? ent_data[rptr] : 32'd0;

  // Enqueue acceptance: drop x0 writes and writes of a thread being flushed,
  // then admit up to the space that exists after this cycle's dequeue.
  always_comb begin
    div_ok   = div_wen && (div_waddr != 5'd0) && !flush[div_tid];
    nbl_ok   = nbl_wen && (nbl_waddr != 5'd0) && !flush[nbl_tid];
    deq_n    = {{AW{1'b0}}, deq};
    space    = DEPTH_C - count + deq_n;
    div_acc  = div_ok && (space != '0);
    nbl_acc  = nbl_ok && (div_acc ? (space >= TWO_C) : (space != '0));
    ovf_now  = (div_ok && !div_acc) || (nbl_ok && !nbl_acc);
    acc_n    = {{AW{1'b0}}, div_acc} + {{AW{1'b0}}, nbl_acc};
    // div is older, so nbl lands behind it when both are accepted.
    nbl_slot = div_acc ? (wptr + {{(AW-1){1'b0}}, 1'b1}) : wptr;
  end

  // Pointers, occupancy, valid bits and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ovf_err   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[ent_tid[i]]) ent_valid[i] <= 1'b0;
      end
      if (deq) begin
        ent_valid[rptr] <= 1'b0;
        rptr            <= rptr + {{(AW-1){1'b0}}, 1'b1};
      end
      // New entries are written last so a slot freed this cycle can be reused.
      if (div_acc) ent_valid[wptr]     <= 1'b1;
      if (nbl_acc) ent_valid[nbl_slot] <= 1'b1;
      wptr  <= wptr + acc_n[AW-1:0];
      count <= count + acc_n - deq_n;
      if (ovf_now) ovf_err <= 1'b1;
    end
  end

  // Entry payload; not reset since valid bits qualify every use.
  always_ff @(posedge clk) begin
    if (div_acc) begin
      ent_tid[wptr]  <= div_tid;
      ent_addr[wptr] <= div_waddr;
      ent_data[wptr] <= div_wd;
    end
    if (nbl_acc) begin
      ent_tid[nbl_slot]  <= nbl_tid;
      ent_addr[nbl_slot] <= nbl_waddr;
      ent_data[nbl_slot] <= nbl_wd;
    end
  end

  // Scoreboard lookup over valid entries, including one draining now.
  always_comb begin
    chk_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_tid[i] == chk_tid) && (ent_addr[i] == chk_addr))
        chk_busy = 1'b1;
    end
    if (chk_addr == 5'd0) chk_busy = 1'b0;
  end

  assign full = (count >= FULL_LVL);

endmodule

// File: tb/tb_eh2_dec_gpr_wb_buf.sv
// Bench for the GPR port 3 writeback buffer: directed stimulus pushes the
// writes it expects into a queue, a monitor pops and compares each write the
// DUT presents, and occupancy/scoreboard/flag checks are made inline.
module tb_eh2_dec_gpr_wb_buf;

  typedef struct packed {
    logic        tid;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_wen, div_tid, nbl_wen, nbl_tid, chk_tid;
  logic [4:0]  div_waddr, nbl_waddr, chk_addr;
  logic [31:0] div_wd, nbl_wd;
  logic [1:0]  flush;
  logic        chk_busy, full, ovf_err;

  int errors = 0;
  int checks = 0;
  wr_t exp_q[$];

  eh2_dec_gpr_wb_buf_if wb ();

  eh2_dec_gpr_wb_buf #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .div_wen(div_wen), .div_tid(div_tid), .div_waddr(div_waddr), .div_wd(div_wd),
    .nbl_wen(nbl_wen), .nbl_tid(nbl_tid), .nbl_waddr(nbl_waddr), .nbl_wd(nbl_wd),
    .flush(flush), .chk_tid(chk_tid), .chk_addr(chk_addr),
    .chk_busy(chk_busy), .full(full), .ovf_err(ovf_err), .wb(wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_chk(input string name, input logic t, input logic [4:0] a, input logic exp);
    chk_tid  = t;
    chk_addr = a;
    #1;
    chk(name, {63'd0, chk_busy}, {63'd0, exp});
  endtask

  task automatic push(input logic t, input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.tid  = t;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic div_in(input logic t, input logic [4:0] a, input logic [31:0] d);
    div_wen = 1'b1; div_tid = t; div_waddr = a; div_wd = d;
  endtask

  task automatic nbl_in(input logic t, input logic [4:0] a, input logic [31:0] d);
    nbl_wen = 1'b1; nbl_tid = t; nbl_waddr = a; nbl_wd = d;
  endtask

  // Monitor: every write presented on port 3 must be the oldest expected one.
  always @(negedge clk) begin
    if (wb.wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got tid=%0d addr=%0d data=%0h, none expected",
                 wb.wtid, wb.waddr, wb.wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checks++;
        if (wb.wtid !== e.tid || wb.waddr !== e.addr || wb.wd !== e.data) begin
          errors++;
          $display("FAIL write_data: got tid=%0d addr=%0d data=%0h expected tid=%0d addr=%0d data=%0h",
                   wb.wtid, wb.waddr, wb.wd, e.tid, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    div_wen = 0; div_tid = 0; div_waddr = 0; div_wd = 0;
    nbl_wen = 0; nbl_tid = 0; nbl_waddr = 0; nbl_wd = 0;
    flush = 2'b00; chk_tid = 0; chk_addr = 0;
    wb.port_free = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    wb.port_free = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_wen", {63'd0, wb.wen}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_err}, 64'd0);
    chk("rst_count", 64'(dut.count), 64'd0);
    busy_chk("rst_busy", 1'b0, 5'd5, 1'b0);

    // Single div write drains exactly one cycle later
    cyc();
    div_in(1'b0, 5'd5, 32'hDEADBEEF); push(1'b0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_no_bypass", {63'd0, wb.wen}, 64'd0);
    cyc(); div_wen = 0;
    @(negedge clk);
    chk("t1_drain_wen", {63'd0, wb.wen}, 64'd1);
    chk("t1_drain_addr", 64'(wb.waddr), 64'd5);
    cyc();
    @(negedge clk);
    chk("t1_count", 64'(dut.count), 64'd0);

    // Dual enqueue, port busy 3 cycles, then in-order drain
    cyc();
    wb.port_free = 1'b0;
    div_in(1'b0, 5'd3, 32'h11); nbl_in(1'b0, 5'd4, 32'h22);
    push(1'b0, 5'd3, 32'h11); push(1'b0, 5'd4, 32'h22);
    cyc(); div_wen = 0; nbl_wen = 0;
    @(negedge clk);
    busy_chk("t2_busy_x4_held", 1'b0, 5'd4, 1'b1);
    busy_chk("t2_busy_x4_tid1", 1'b1, 5'd4, 1'b0);
    cyc(); cyc();
    wb.port_free = 1'b1;
    @(negedge clk);
    busy_chk("t2_busy_x4_first", 1'b0, 5'd4, 1'b1);
    chk("t2_first_addr", 64'(wb.waddr), 64'd3);
    cyc();
    @(negedge clk);
    busy_chk("t2_busy_x4_draining", 1'b0, 5'd4, 1'b1);
    chk("t2_second_addr", 64'(wb.waddr), 64'd4);
    cyc();
    @(negedge clk);
    busy_chk("t2_busy_x4_done", 1'b0, 5'd4, 1'b0);
    chk("t2_count", 64'(dut.count), 64'd0);

    // Fill to DEPTH-1, 2-in/1-out at full, then overflow
    cyc();
    wb.port_free = 1'b0;
    div_in(1'b0, 5'd1, 32'hA1); nbl_in(1'b0, 5'd2, 32'hA2);
    push(1'b0, 5'd1, 32'hA1); push(1'b0, 5'd2, 32'hA2);
    cyc(); nbl_wen = 0;
    div_in(1'b0, 5'd3, 32'hA3); push(1'b0, 5'd3, 32'hA3);
    cyc(); div_wen = 0;
    @(negedge clk);
    chk("t3_full_at_3", {63'd0, full}, 64'd1);
    chk("t3_count_3", 64'(dut.count), 64'd3);
    cyc();
    wb.port_free = 1'b1;
    div_in(1'b0, 5'd4, 32'hA4); nbl_in(1'b0, 5'd5, 32'hA5);
    push(1'b0, 5'd4, 32'hA4); push(1'b0, 5'd5, 32'hA5);
    cyc(); div_wen = 0; nbl_wen = 0; wb.port_free = 1'b0;
    @(negedge clk);
    chk("t3_count_4", 64'(dut.count), 64'd4);
    chk("t3_no_ovf", {63'd0, ovf_err}, 64'd0);
    cyc();
    div_in(1'b0, 5'd6, 32'hA6);
    cyc(); div_wen = 0;
    @(negedge clk);
    chk("t3_ovf_set", {63'd0, ovf_err}, 64'd1);
    chk("t3_count_sat", 64'(dut.count), 64'd4);
    cyc(); cyc();
    wb.port_free = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("t3_drained", 64'(dut.count), 64'd0);
    chk("t3_ovf_sticky", {63'd0, ovf_err}, 64'd1);
    cyc();
    wb.port_free = 1'b0;
    rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("t3_ovf_cleared", {63'd0, ovf_err}, 64'd0);

    // Thread-1 flush leaves only tid0 x8
    cyc();
    div_in(1'b1, 5'd7, 32'h77); nbl_in(1'b0, 5'd8, 32'h88);
    cyc(); nbl_wen = 0;
    div_in(1'b1, 5'd9, 32'h99);
    cyc(); div_wen = 0;
    flush = 2'b10;
    @(negedge clk);
    busy_chk("t4_busy_x7_pre", 1'b1, 5'd7, 1'b1);
    cyc(); flush = 2'b00;
    push(1'b0, 5'd8, 32'h88);
    @(negedge clk);
    busy_chk("t4_busy_x7_post", 1'b1, 5'd7, 1'b0);
    busy_chk("t4_busy_x9_post", 1'b1, 5'd9, 1'b0);
    busy_chk("t4_busy_x8_kept", 1'b0, 5'd8, 1'b1);
    chk("t4_count_slots", 64'(dut.count), 64'd3);
    cyc();
    wb.port_free = 1'b1;
    @(negedge clk);
    chk("t4_skip_wen", {63'd0, wb.wen}, 64'd0);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("t4_count_done", 64'(dut.count), 64'd0);

    // x0 destination is never buffered
    cyc();
    nbl_in(1'b0, 5'd0, 32'hFFFF);
    @(negedge clk);
    busy_chk("t5_busy_x0", 1'b0, 5'd0, 1'b0);
    cyc(); nbl_wen = 0;
    @(negedge clk);
    chk("t5_count", 64'(dut.count), 64'd0);
    cyc(); cyc();

    // Reset with 3 pending entries, then normal operation
    wb.port_free = 1'b0;
    div_in(1'b0, 5'd10, 32'h10); nbl_in(1'b1, 5'd11, 32'h11);
    cyc(); nbl_wen = 0;
    div_in(1'b0, 5'd12, 32'h12);
    cyc(); div_wen = 0;
    @(negedge clk);
    chk("t6_count_pre", 64'(dut.count), 64'd3);
    chk("t6_full_pre", {63'd0, full}, 64'd1);
    cyc();
    rst = 1'b1;
    cyc(); rst = 1'b0; wb.port_free = 1'b1;
    @(negedge clk);
    chk("t6_count_post", 64'(dut.count), 64'd0);
    chk("t6_wen_post", {63'd0, wb.wen}, 64'd0);
    chk("t6_full_post", {63'd0, full}, 64'd0);
    busy_chk("t6_busy_post", 1'b0, 5'd10, 1'b0);
    cyc();
    div_in(1'b1, 5'd13, 32'h00C0FFEE); push(1'b1, 5'd13, 32'h00C0FFEE);
    cyc(); div_wen = 0;
    @(negedge clk);
    chk("t6_drain_wen", {63'd0, wb.wen}, 64'd1);
    cyc(); cyc();
    @(negedge clk);
    chk("t6_count_end", 64'(dut.count), 64'd0);

    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
